// File: rtl/hazard_resolution_unit.sv
// Pipeline hazard controller: decides one cycle ahead when EX->MA must stall for
// load-use, multi-cycle MMIO loads or the two-phase AMO, and drives the phase strobes.
module hazard_resolution_unit #(
    parameter int unsigned     XLEN              = 32,
    parameter logic [XLEN-1:0] MMIO_ADDR         = 32'h4000_0000,
    parameter logic [XLEN-1:0] MMIO_SIZE_BYTES   = 32'h28,
    parameter int unsigned     MMIO_LOAD_LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ext_stall,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_load,
    input  logic            i_ex_is_lr,
    input  logic            i_ex_is_amo,
    input  logic [4:0]      i_ex_dest_reg,
    input  logic [XLEN-1:0] i_ex_mem_addr,
    input  logic [4:0]      i_id_source_reg_1,
    input  logic [4:0]      i_id_source_reg_2,
    input  logic            i_id_uses_rs1,
    input  logic            i_id_uses_rs2,
    output logic            o_stall,
    output logic            o_load_use_hazard_detected,
    output logic            o_stall_for_load_use_hazard,
    output logic            o_amo_read_phase,
    output logic            o_amo_write_phase
);

    typedef enum logic [2:0] {
        RUN,
        LU_STALL,
        MMIO_WAIT,
        AMO_READ,
        AMO_WRITE
    } state_e;

    // One extra bit on the window bounds so a window ending at the top of memory cannot wrap.
    localparam logic [XLEN:0] MMIO_LO = {1'b0, MMIO_ADDR};
    localparam logic [XLEN:0] MMIO_HI = MMIO_LO + {1'b0, MMIO_SIZE_BYTES};
    localparam logic [3:0]    LAT     = 4'(MMIO_LOAD_LATENCY);

    state_e     state_q, state_d;
    logic       lu_flag_q, lu_flag_d;
    logic       first_q, first_d;
    logic [3:0] cnt_q, cnt_d;

    logic            ex_mem;
    logic            mmio_hit;
    logic            dep;
    logic [XLEN:0]   addr_ext;

    assign addr_ext = {1'b0, i_ex_mem_addr};
    assign ex_mem   = i_ex_valid & (i_ex_is_load | i_ex_is_lr | i_ex_is_amo);
    assign mmio_hit = (i_ex_is_load | i_ex_is_lr) & (addr_ext >= MMIO_LO) & (addr_ext < MMIO_HI);
    assign dep      = ex_mem & (i_ex_dest_reg != 5'd0)
                    & ((i_id_uses_rs1 & (i_ex_dest_reg == i_id_source_reg_1))
                     | (i_id_uses_rs2 & (i_ex_dest_reg == i_id_source_reg_2)));

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        lu_flag_d = lu_flag_q;
        cnt_d     = cnt_q;
        first_d   = 1'b0;
        case (state_q)
            RUN: begin
                // A new decision is taken only when the EX instruction really advances.
                if (!i_ext_stall) begin
                    if (i_ex_valid && i_ex_is_amo) begin
                        state_d = AMO_READ;
                    end else if (i_ex_valid && mmio_hit) begin
                        state_d = MMIO_WAIT;
                        cnt_d   = LAT;
                    end else if (dep) begin
                        state_d = LU_STALL;
                    end
                    if (state_d != RUN) begin
                        lu_flag_d = dep;
                        first_d   = 1'b1;
                    end
                end
            end
            LU_STALL: begin
                state_d   = RUN;
                lu_flag_d = 1'b0;
            end
            MMIO_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = RUN;
                    lu_flag_d = 1'b0;
                end
            end
            AMO_READ: begin
                state_d = AMO_WRITE;
            end
            AMO_WRITE: begin
                state_d   = RUN;
                lu_flag_d = 1'b0;
            end
            default: begin
                state_d   = RUN;
                lu_flag_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= RUN;
            lu_flag_q <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            lu_flag_q <= lu_flag_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_stall                     = (state_q != RUN) | i_ext_stall;
    assign o_stall_for_load_use_hazard = (state_q == LU_STALL)
                                       | (lu_flag_q & ((state_q == MMIO_WAIT) | (state_q == AMO_READ)));
    assign o_load_use_hazard_detected  = lu_flag_q & first_q;
    assign o_amo_read_phase            = (state_q == AMO_READ);
    assign o_amo_write_phase           = (state_q == AMO_WRITE);

endmodule
